// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : Burst reader for serial NOR flash. A burst is started from
//               IDLE. It selects the flash and sends the read command, a
//               24-bit address, an optional dummy byte and then one 0x00
//               byte per data byte through an external SPI byte engine. Each
//               received data byte is presented on rd_data with a one-cycle
//               rd_valid strobe. The burst ends with a one-cycle done pulse.
//
//               Build option SPI_FLASH_READER_FAST_READ_EN:
//                 defined   -> FAST_READ (0x0B) plus one discarded dummy byte
//                 undefined -> READ (0x03), no dummy byte
//
// Ports       : clk        system clock, rising edge
//               reset      synchronous active-high reset
//               start      request a burst (sampled in IDLE only)
//               addr[23:0] flash byte address, captured on start
//               len[7:0]   byte count, captured on start, 0 means 256
//               busy       burst in progress
//               done       one-cycle pulse at end of burst
//               rd_data    received data byte
//               rd_valid   one-cycle strobe qualifying rd_data
//               cs_n       flash chip select, active low
//               spi_start  one-cycle byte request to the SPI byte engine
//               spi_tx     byte to transmit, held until the next request
//               spi_busy   SPI byte engine busy
//               spi_rx     byte received, valid when spi_busy falls
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] c_CMD       = 8'h0B;
  localparam logic [2:0] c_HDR_BYTES = 3'd5;  // cmd + 3 addr + dummy
`else
  localparam logic [7:0] c_CMD       = 8'h03;
  localparam logic [2:0] c_HDR_BYTES = 3'd4;  // cmd + 3 addr
`endif

  // Last timer value of SETUP / HOLD; a zero cycle count still gives one cycle.
  localparam logic [15:0] c_SETUP_LAST = 16'((CS_SETUP_CYCLES > 1) ? CS_SETUP_CYCLES - 1 : 0);
  localparam logic [15:0] c_HOLD_LAST  = 16'((CS_HOLD_CYCLES  > 1) ? CS_HOLD_CYCLES  - 1 : 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_HOLD      = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  logic [2:0]  r_state;
  logic [23:0] r_addr;
  logic [8:0]  r_remaining;
  // Index of the byte in flight. It saturates at c_HDR_BYTES, so every
  // value at or above the header length denotes a data byte.
  logic [2:0]  r_idx;
  logic [15:0] r_timer;

  logic [2:0]  w_idx_next;
  logic [7:0]  w_tx_next;
  logic        w_is_data;

  assign w_is_data = (r_idx >= c_HDR_BYTES);

  // Index and transmit byte of the next transfer to be issued.
  always_comb begin
    w_idx_next = r_idx;
    if (r_state == S_SETUP) begin
      w_idx_next = 3'd0;
    end else if (r_idx < c_HDR_BYTES) begin
      w_idx_next = r_idx + 3'd1;
    end

    w_tx_next = 8'h00;  // dummy and data bytes shift out zeros
    case (w_idx_next)
      3'd0:    w_tx_next = c_CMD;
      3'd1:    w_tx_next = r_addr[23:16];
      3'd2:    w_tx_next = r_addr[15:8];
      3'd3:    w_tx_next = r_addr[7:0];
      default: w_tx_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 24'h000000;
      r_remaining <= 9'd0;
      r_idx       <= 3'd0;
      r_timer     <= 16'd0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= 8'h00;
      spi_start   <= 1'b0;
      spi_tx      <= 8'h00;
    end else begin
      // Single-cycle strobes default low.
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      spi_start <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= addr;
            r_remaining <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            r_timer     <= 16'd0;
            cs_n        <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_timer == c_SETUP_LAST) begin
            r_idx     <= w_idx_next;
            spi_tx    <= w_tx_next;
            spi_start <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        // spi_start is high for exactly this one cycle.
        S_ISSUE: begin
          r_state <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (spi_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end

        // Received byte is only forwarded for data bytes; header and
        // dummy bytes are dropped here.
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            if (w_is_data) begin
              rd_data     <= spi_rx;
              rd_valid    <= 1'b1;
              r_remaining <= r_remaining - 9'd1;
            end
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (w_is_data && (r_remaining == 9'd0)) begin
            r_timer <= 16'd0;
            r_state <= S_HOLD;
          end else begin
            r_idx     <= w_idx_next;
            spi_tx    <= w_tx_next;
            spi_start <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end

        S_HOLD: begin
          if (r_timer == c_HOLD_LAST) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        // start is not looked at here, which guarantees at least the
        // FINISH cycle with cs_n high between consecutive bursts.
        S_FINISH: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
